ahb_front_tl_buffer: RTL and testbench



---
 rtl/ahb_front_tl_pkg.sv | 28 ++
 rtl/ahb_front_tl_buffer_queue.sv | 63 ++++++
 rtl/ahb_front_tl_buffer.sv | 165 ++++++++++++++++
 tb/tb_ahb_front_tl_buffer.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_front_tl_pkg.sv
// Shared TileLink-UL opcode constants and payload structs for the AHB front-port buffer.
// The source ID is carried beside these structs because its width is a per-instance parameter.
package ahb_front_tl_pkg;

    localparam logic [2:0] TL_A_PUT_FULL        = 3'd0;
    localparam logic [2:0] TL_A_PUT_PARTIAL     = 3'd1;
    localparam logic [2:0] TL_A_GET             = 3'd4;
    localparam logic [2:0] TL_D_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] TL_D_ACCESS_ACK_DATA = 3'd1;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [2:0]  param;
        logic [2:0]  size;
        logic [31:0] address;
        logic [3:0]  mask;
        logic [31:0] data;
    } tl_a_pl_t;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [2:0]  size;
        logic        denied;
        logic        corrupt;
        logic [31:0] data;
    } tl_d_pl_t;

endpackage

// File: rtl/ahb_front_tl_buffer_queue.sv
// Generic 2-entry registered FIFO. Both ready and valid come straight from the occupancy register,
// so nothing on the push side depends combinationally on the pop side or vice versa.
module tl_queue2 #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         push_valid,
    output logic         push_ready,
    input  logic [W-1:0] push_data,
    output logic         pop_valid,
    input  logic         pop_ready,
    output logic [W-1:0] pop_data
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic [1:0]   count_next;
    logic         push_fire;
    logic         pop_fire;

    assign push_ready = (count != 2'd2);
    assign pop_valid  = (count != 2'd0);
    assign push_fire  = push_valid && push_ready;
    assign pop_fire   = pop_valid && pop_ready;

    // Storage is not reset; the empty-gate keeps stale contents off the output.
    assign pop_data = pop_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clock) begin
        if (push_fire) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_comb begin
        count_next = count;
        case ({push_fire, pop_fire})
            2'b10:   count_next = count + 2'd1;
            2'b01:   count_next = count - 2'd1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push_fire) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop_fire) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count_next;
        end
    end

endmodule

// File: rtl/ahb_front_tl_buffer.sv
// Registered TileLink-UL buffer between the AHB front-port bridge and the fabric:
// 2-entry A and D queues, an outstanding-request cap, and a sticky unexpected-response flag.
module ahb_front_tl_buffer
    import ahb_front_tl_pkg::*;
#(
    parameter int SRC_W        = 1,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic             clock,
    input  logic             reset_n,

    input  logic             up_a_valid,
    output logic             up_a_ready,
    input  logic [2:0]       up_a_opcode,
    input  logic [2:0]       up_a_param,
    input  logic [2:0]       up_a_size,
    input  logic [SRC_W-1:0] up_a_source,
    input  logic [31:0]      up_a_address,
    input  logic [3:0]       up_a_mask,
    input  logic [31:0]      up_a_data,

    output logic             dn_a_valid,
    input  logic             dn_a_ready,
    output logic [2:0]       dn_a_opcode,
    output logic [2:0]       dn_a_param,
    output logic [2:0]       dn_a_size,
    output logic [SRC_W-1:0] dn_a_source,
    output logic [31:0]      dn_a_address,
    output logic [3:0]       dn_a_mask,
    output logic [31:0]      dn_a_data,

    input  logic             dn_d_valid,
    output logic             dn_d_ready,
    input  logic [2:0]       dn_d_opcode,
    input  logic [2:0]       dn_d_size,
    input  logic [SRC_W-1:0] dn_d_source,
    input  logic             dn_d_denied,
    input  logic             dn_d_corrupt,
    input  logic [31:0]      dn_d_data,

    output logic             up_d_valid,
    input  logic             up_d_ready,
    output logic [2:0]       up_d_opcode,
    output logic [2:0]       up_d_size,
    output logic [SRC_W-1:0] up_d_source,
    output logic             up_d_denied,
    output logic             up_d_corrupt,
    output logic [31:0]      up_d_data,

    output logic [3:0]       inflight,
    output logic             err_unexpected_d
);

    localparam int A_W = $bits(tl_a_pl_t) + SRC_W;
    localparam int D_W = $bits(tl_d_pl_t) + SRC_W;
    localparam logic [3:0] LIMIT = 4'(MAX_INFLIGHT);

    // Handshake: a beat transfers on a rising edge where valid and ready are both high;
    // valid never waits on ready, and every valid/ready here is a function of registers only.

    tl_a_pl_t         a_in_pl;
    tl_a_pl_t         a_out_pl;
    tl_d_pl_t         d_in_pl;
    tl_d_pl_t         d_out_pl;
    logic [A_W-1:0]   a_in_word;
    logic [A_W-1:0]   a_out_word;
    logic [D_W-1:0]   d_in_word;
    logic [D_W-1:0]   d_out_word;

    logic             a_q_valid;
    logic             issue_ok;
    logic             a_fire;
    logic             d_in_fire;
    logic             d_out_fire;
    logic             unexpected;
    logic [3:0]       inflight_next;

    always_comb begin
        a_in_pl         = '0;
        a_in_pl.opcode  = up_a_opcode;
        a_in_pl.param   = up_a_param;
        a_in_pl.size    = up_a_size;
        a_in_pl.address = up_a_address;
        a_in_pl.mask    = up_a_mask;
        a_in_pl.data    = up_a_data;
        d_in_pl         = '0;
        d_in_pl.opcode  = dn_d_opcode;
        d_in_pl.size    = dn_d_size;
        d_in_pl.denied  = dn_d_denied;
        d_in_pl.corrupt = dn_d_corrupt;
        d_in_pl.data    = dn_d_data;
    end

    assign a_in_word = {up_a_source, a_in_pl};
    assign d_in_word = {dn_d_source, d_in_pl};

    // The A pop is held off entirely while the outstanding cap is reached.
    assign issue_ok   = (inflight < LIMIT);
    assign dn_a_valid = a_q_valid && issue_ok;

    tl_queue2 #(.W(A_W)) u_a_queue (
        .clock      (clock),
        .reset_n    (reset_n),
        .push_valid (up_a_valid),
        .push_ready (up_a_ready),
        .push_data  (a_in_word),
        .pop_valid  (a_q_valid),
        .pop_ready  (dn_a_ready && issue_ok),
        .pop_data   (a_out_word)
    );

    tl_queue2 #(.W(D_W)) u_d_queue (
        .clock      (clock),
        .reset_n    (reset_n),
        .push_valid (dn_d_valid),
        .push_ready (dn_d_ready),
        .push_data  (d_in_word),
        .pop_valid  (up_d_valid),
        .pop_ready  (up_d_ready),
        .pop_data   (d_out_word)
    );

    assign {dn_a_source, a_out_pl} = a_out_word;
    assign {up_d_source, d_out_pl} = d_out_word;

    assign dn_a_opcode  = a_out_pl.opcode;
    assign dn_a_param   = a_out_pl.param;
    assign dn_a_size    = a_out_pl.size;
    assign dn_a_address = a_out_pl.address;
    assign dn_a_mask    = a_out_pl.mask;
    assign dn_a_data    = a_out_pl.data;

    assign up_d_opcode  = d_out_pl.opcode;
    assign up_d_size    = d_out_pl.size;
    assign up_d_denied  = d_out_pl.denied;
    assign up_d_corrupt = d_out_pl.corrupt;
    assign up_d_data    = d_out_pl.data;

    assign a_fire     = dn_a_valid && dn_a_ready;
    assign d_in_fire  = dn_d_valid && dn_d_ready;
    assign d_out_fire = up_d_valid && up_d_ready;

    // A response is unexpected only if nothing is outstanding and no earlier response is still queued.
    assign unexpected = d_in_fire && (inflight == 4'd0) && !up_d_valid;

    always_comb begin
        inflight_next = inflight;
        if (a_fire && !d_out_fire) begin
            inflight_next = inflight + 4'd1;
        end else if (d_out_fire && !a_fire && (inflight != 4'd0)) begin
            inflight_next = inflight - 4'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            inflight         <= 4'd0;
            err_unexpected_d <= 1'b0;
        end else begin
            inflight         <= inflight_next;
            err_unexpected_d <= err_unexpected_d || unexpected;
        end
    end

endmodule

// File: tb/tb_ahb_front_tl_buffer.sv
// Directed bench for ahb_front_tl_buffer with hand-computed expectations and an ordered scoreboard.
module tb_ahb_front_tl_buffer;

    localparam int SRC_W = 1;

    logic             clock;
    logic             reset_n;
    logic             up_a_valid;
    logic             up_a_ready;
    logic [2:0]       up_a_opcode;
    logic [2:0]       up_a_param;
    logic [2:0]       up_a_size;
    logic [SRC_W-1:0] up_a_source;
    logic [31:0]      up_a_address;
    logic [3:0]       up_a_mask;
    logic [31:0]      up_a_data;
    logic             dn_a_valid;
    logic             dn_a_ready;
    logic [2:0]       dn_a_opcode;
    logic [2:0]       dn_a_param;
    logic [2:0]       dn_a_size;
    logic [SRC_W-1:0] dn_a_source;
    logic [31:0]      dn_a_address;
    logic [3:0]       dn_a_mask;
    logic [31:0]      dn_a_data;
    logic             dn_d_valid;
    logic             dn_d_ready;
    logic [2:0]       dn_d_opcode;
    logic [2:0]       dn_d_size;
    logic [SRC_W-1:0] dn_d_source;
    logic             dn_d_denied;
    logic             dn_d_corrupt;
    logic [31:0]      dn_d_data;
    logic             up_d_valid;
    logic             up_d_ready;
    logic [2:0]       up_d_opcode;
    logic [2:0]       up_d_size;
    logic [SRC_W-1:0] up_d_source;
    logic             up_d_denied;
    logic             up_d_corrupt;
    logic [31:0]      up_d_data;
    logic [3:0]       inflight;
    logic             err_unexpected_d;

    int n_checks;
    int n_fail;
    logic [63:0] exp_q[$];

    ahb_front_tl_buffer #(.SRC_W(SRC_W), .MAX_INFLIGHT(4)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .up_a_valid       (up_a_valid),
        .up_a_ready       (up_a_ready),
        .up_a_opcode      (up_a_opcode),
        .up_a_param       (up_a_param),
        .up_a_size        (up_a_size),
        .up_a_source      (up_a_source),
        .up_a_address     (up_a_address),
        .up_a_mask        (up_a_mask),
        .up_a_data        (up_a_data),
        .dn_a_valid       (dn_a_valid),
        .dn_a_ready       (dn_a_ready),
        .dn_a_opcode      (dn_a_opcode),
        .dn_a_param       (dn_a_param),
        .dn_a_size        (dn_a_size),
        .dn_a_source      (dn_a_source),
        .dn_a_address     (dn_a_address),
        .dn_a_mask        (dn_a_mask),
        .dn_a_data        (dn_a_data),
        .dn_d_valid       (dn_d_valid),
        .dn_d_ready       (dn_d_ready),
        .dn_d_opcode      (dn_d_opcode),
        .dn_d_size        (dn_d_size),
        .dn_d_source      (dn_d_source),
        .dn_d_denied      (dn_d_denied),
        .dn_d_corrupt     (dn_d_corrupt),
        .dn_d_data        (dn_d_data),
        .up_d_valid       (up_d_valid),
        .up_d_ready       (up_d_ready),
        .up_d_opcode      (up_d_opcode),
        .up_d_size        (up_d_size),
        .up_d_source      (up_d_source),
        .up_d_denied      (up_d_denied),
        .up_d_corrupt     (up_d_corrupt),
        .up_d_data        (up_d_data),
        .inflight         (inflight),
        .err_unexpected_d (err_unexpected_d)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // drivers
    task automatic drive_a(input logic valid, input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] data, input logic [SRC_W-1:0] src);
        up_a_valid   = valid;
        up_a_opcode  = op;
        up_a_param   = 3'd0;
        up_a_size    = 3'd2;
        up_a_source  = src;
        up_a_address = addr;
        up_a_mask    = 4'hf;
        up_a_data    = data;
    endtask

    task automatic drive_d(input logic valid, input logic [2:0] op, input logic [31:0] data,
                           input logic [SRC_W-1:0] src);
        dn_d_valid   = valid;
        dn_d_opcode  = op;
        dn_d_size    = 3'd2;
        dn_d_source  = src;
        dn_d_denied  = 1'b0;
        dn_d_corrupt = 1'b0;
        dn_d_data    = data;
    endtask

    initial begin
        int first_c;
        int last_c;
        int seen;
        int issued;
        logic fire_p1;
        logic fire_p2;
        logic [63:0] exp_beat;

        n_checks = 0;
        n_fail   = 0;
        drive_a(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
        drive_d(1'b0, 3'd0, 32'h0, 1'b0);
        dn_a_ready = 1'b1;
        up_d_ready = 1'b1;

        // reset state
        reset_n = 1'b0;
        #12;
        check("rst_up_a_ready", 64'(up_a_ready), 64'd1);
        check("rst_dn_d_ready", 64'(dn_d_ready), 64'd1);
        check("rst_dn_a_valid", 64'(dn_a_valid), 64'd0);
        check("rst_up_d_valid", 64'(up_d_valid), 64'd0);
        check("rst_inflight", 64'(inflight), 64'd0);
        check("rst_err", 64'(err_unexpected_d), 64'd0);
        check("rst_dn_a_address", 64'(dn_a_address), 64'd0);
        check("rst_up_d_data", 64'(up_d_data), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // single Get and its AccessAckData
        drive_a(1'b1, 3'd4, 32'h2000_0000, 32'h0, 1'b0);
        tick();
        check("get_dn_a_valid", 64'(dn_a_valid), 64'd1);
        check("get_dn_a_address", 64'(dn_a_address), 64'h2000_0000);
        check("get_dn_a_opcode", 64'(dn_a_opcode), 64'd4);
        check("get_dn_a_source", 64'(dn_a_source), 64'd0);
        check("get_dn_a_mask", 64'(dn_a_mask), 64'hf);
        up_a_valid = 1'b0;
        tick();
        check("get_inflight_1", 64'(inflight), 64'd1);
        check("get_dn_a_drained", 64'(dn_a_valid), 64'd0);
        drive_d(1'b1, 3'd1, 32'hDEAD_BEEF, 1'b0);
        tick();
        check("ack_up_d_valid", 64'(up_d_valid), 64'd1);
        check("ack_up_d_data", 64'(up_d_data), 64'hDEAD_BEEF);
        check("ack_up_d_opcode", 64'(up_d_opcode), 64'd1);
        dn_d_valid = 1'b0;
        tick();
        check("ack_inflight_0", 64'(inflight), 64'd0);
        check("ack_up_d_drained", 64'(up_d_valid), 64'd0);
        check("ack_no_err", 64'(err_unexpected_d), 64'd0);

        // back-to-back PutFull, D returned one cycle after each A issue
        do_reset();
        first_c = -1;
        last_c  = -1;
        seen    = 0;
        fire_p1 = 1'b0;
        fire_p2 = 1'b0;
        for (int c = 0; c < 16; c++) begin
            if (c < 8) begin
                drive_a(1'b1, 3'd0, 32'h1000 + 32'(4 * c), 32'hA000_0000 + 32'(c), 1'b0);
                exp_q.push_back({32'h1000 + 32'(4 * c), 32'hA000_0000 + 32'(c)});
            end else begin
                up_a_valid = 1'b0;
            end
            drive_d(fire_p2, 3'd0, 32'h0, 1'b0);
            tick();
            fire_p2 = fire_p1;
            fire_p1 = dn_a_valid;
            if (dn_a_valid) begin
                if (first_c < 0) first_c = c;
                last_c = c;
                seen++;
                exp_beat = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
                check("b2b_beat", {dn_a_address, dn_a_data}, exp_beat);
            end
        end
        dn_d_valid = 1'b0;
        check("b2b_count", 64'(seen), 64'd8);
        check("b2b_no_bubble", 64'(last_c - first_c + 1), 64'd8);
        check("b2b_first_latency", 64'(first_c), 64'd0);
        check("b2b_queue_empty", 64'(exp_q.size()), 64'd0);
        tick();
        tick();
        check("b2b_inflight_0", 64'(inflight), 64'd0);
        check("b2b_no_err", 64'(err_unexpected_d), 64'd0);

        // inflight limit with D withheld
        do_reset();
        up_d_ready = 1'b0;
        issued = 0;
        for (int c = 0; c < 10; c++) begin
            if (c < 6) drive_a(1'b1, 3'd4, 32'h3000 + 32'(c), 32'h0, 1'b0);
            else up_a_valid = 1'b0;
            tick();
            if (dn_a_valid) issued++;
        end
        check("lim_issued", 64'(issued), 64'd4);
        check("lim_inflight", 64'(inflight), 64'd4);
        check("lim_dn_a_valid", 64'(dn_a_valid), 64'd0);
        check("lim_up_a_ready", 64'(up_a_ready), 64'd0);
        drive_d(1'b1, 3'd1, 32'h1234_5678, 1'b0);
        tick();
        dn_d_valid = 1'b0;
        up_d_ready = 1'b1;
        tick();
        up_d_ready = 1'b0;
        check("lim_release_inflight", 64'(inflight), 64'd3);
        check("lim_release_valid", 64'(dn_a_valid), 64'd1);
        check("lim_release_head", 64'(dn_a_address), 64'h3004);
        tick();
        check("lim_reissue_inflight", 64'(inflight), 64'd4);
        check("lim_reissue_gate", 64'(dn_a_valid), 64'd0);
        check("lim_reissue_ready", 64'(up_a_ready), 64'd1);
        up_d_ready = 1'b1;

        // backpressure: dn_a_ready low for 5 cycles
        do_reset();
        dn_a_ready = 1'b0;
        drive_a(1'b1, 3'd0, 32'h4000, 32'h1111_1111, 1'b0);
        tick();
        drive_a(1'b1, 3'd0, 32'h4004, 32'h2222_2222, 1'b0);
        tick();
        drive_a(1'b1, 3'd0, 32'h4008, 32'h3333_3333, 1'b0);
        check("bp_up_a_ready_full", 64'(up_a_ready), 64'd0);
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bp_stall_beat", {32'(dn_a_valid), dn_a_address, dn_a_data}, {32'd1, 32'h4000, 32'h1111_1111});
        end
        check("bp_still_full", 64'(up_a_ready), 64'd0);
        dn_a_ready = 1'b1;
        tick();
        check("bp_ready_after_pop", 64'(up_a_ready), 64'd1);
        check("bp_head_after_pop", 64'(dn_a_address), 64'h4004);
        tick();
        up_a_valid = 1'b0;
        check("bp_third_beat", {dn_a_address, dn_a_data}, {32'h4008, 32'h3333_3333});
        tick();
        check("bp_inflight", 64'(inflight), 64'd3);

        // unexpected D with nothing outstanding
        do_reset();
        up_d_ready = 1'b0;
        drive_d(1'b1, 3'd0, 32'hCAFE_0001, 1'b1);
        tick();
        dn_d_valid = 1'b0;
        check("unx_err_set", 64'(err_unexpected_d), 64'd1);
        check("unx_beat_queued", {32'(up_d_valid), up_d_data}, {32'd1, 32'hCAFE_0001});
        check("unx_source", 64'(up_d_source), 64'd1);
        up_d_ready = 1'b1;
        tick();
        check("unx_inflight_sat", 64'(inflight), 64'd0);
        check("unx_delivered", 64'(up_d_valid), 64'd0);
        tick();
        check("unx_err_sticky", 64'(err_unexpected_d), 64'd1);

        // reset in the middle of traffic
        do_reset();
        dn_a_ready = 1'b1;
        up_d_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            drive_a(1'b1, 3'd4, 32'h5000 + 32'(c), 32'h0, 1'b0);
            tick();
        end
        dn_a_ready = 1'b0;
        drive_a(1'b1, 3'd4, 32'h5004, 32'h0, 1'b0);
        tick();
        up_a_valid = 1'b0;
        drive_d(1'b1, 3'd1, 32'h0BAD_F00D, 1'b0);
        tick();
        dn_d_valid = 1'b0;
        check("mid_pre_inflight", 64'(inflight), 64'd3);
        check("mid_pre_a_full", 64'(up_a_ready), 64'd0);
        check("mid_pre_d_valid", 64'(up_d_valid), 64'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_valids", {62'd0, dn_a_valid, up_d_valid}, 64'd0);
        check("mid_rst_inflight", 64'(inflight), 64'd0);
        check("mid_rst_err", 64'(err_unexpected_d), 64'd0);
        check("mid_rst_ready", {62'd0, up_a_ready, dn_d_ready}, 64'd3);
        @(negedge clock);
        reset_n = 1'b1;
        dn_a_ready = 1'b1;
        up_d_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("mid_no_stale", {62'd0, dn_a_valid, up_d_valid}, 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
